// File: rtl/coin_input_conditioner.sv
// Coin input conditioner: synchronises and debounces the four raw coin
// buttons, turns each clean rising press into a coin event, queues events
// and presents them one at a time with the coin value pre-decoded.
//
// Ports:
//   CLK          system clock, rising edge
//   n_reset      asynchronous active-low reset
//   Enable       when 0, new coin edges are discarded; queue still drains
//   OneDollar, FiftyCents, TenCents, FiveCents   raw async buttons
//   coin_ready   consumer accepts the head event this cycle
//   coin_valid   head event available
//   coin_value   head value in cents (100/50/10/5), 0 when idle
//   coin_code    head one-hot {dollar,fifty,ten,five}, 0 when idle
//   *_d          debounced button levels
//   fifo_level   number of queued events
//   drop_cnt     saturating count of discarded presses
module coin_input_conditioner #(
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned CNT_W     = 5,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PTR_W     = 2
) (
    input  logic             CLK,
    input  logic             n_reset,
    input  logic             Enable,
    input  logic             OneDollar,
    input  logic             FiftyCents,
    input  logic             TenCents,
    input  logic             FiveCents,
    input  logic             coin_ready,
    output logic             coin_valid,
    output logic [6:0]       coin_value,
    output logic [3:0]       coin_code,
    output logic             OneDollar_d,
    output logic             FiftyCents_d,
    output logic             TenCents_d,
    output logic             FiveCents_d,
    output logic [PTR_W:0]   fifo_level,
    output logic [7:0]       drop_cnt
);

    localparam int unsigned NCH    = 4;
    localparam int unsigned CODE_W = 2;
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned DROP_W = 8;

    // Channel index: 3 = dollar, 2 = fifty, 1 = ten, 0 = five.
    logic [NCH-1:0]             raw;
    logic [NCH-1:0]             sync1;
    logic [NCH-1:0]             sync2;
    logic [NCH-1:0][CNT_W-1:0]  db_cnt;
    logic [NCH-1:0]             db_lvl;
    logic [NCH-1:0]             db_prev;
    logic [NCH-1:0]             rise;
    logic [NCH-1:0]             pend;
    logic [NCH-1:0]             pend_next;
    logic [NCH-1:0]             accept;
    logic [NCH-1:0]             drop;
    logic [NCH-1:0]             grant;
    logic [CODE_W-1:0]          push_code;
    logic                       push;
    logic                       pop;
    logic                       full;
    logic                       can_push;
    logic [2:0]                 n_drop;
    logic [DROP_W:0]            drop_sum;
    logic [DEPTH-1:0][CODE_W-1:0] mem;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CODE_W-1:0]          head;

    assign raw = {OneDollar, FiftyCents, TenCents, FiveCents};

    // Two-flop synchronisers on every raw button.
    always_ff @(posedge CLK or negedge n_reset) begin
        if (!n_reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: level follows the sample only after DB_CYCLES consecutive
    // differing samples; any return to equality restarts the count.
    always_ff @(posedge CLK or negedge n_reset) begin
        if (!n_reset) begin
            db_cnt  <= '0;
            db_lvl  <= '0;
            db_prev <= '0;
        end else begin
            db_prev <= db_lvl;
            for (int i = 0; i < NCH; i++) begin
                if (sync2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
                    db_lvl[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = db_lvl & ~db_prev;

    // Pop / push qualification and fixed-priority arbiter.
    assign pop      = coin_valid & coin_ready;
    assign full     = (fifo_level == LVL_W'(DEPTH));
    assign can_push = ~full | pop;

    always_comb begin
        grant     = '0;
        push_code = '0;
        if (can_push) begin
            if (pend[3]) begin
                grant     = 4'b1000;
                push_code = 2'd3;
            end else if (pend[2]) begin
                grant     = 4'b0100;
                push_code = 2'd2;
            end else if (pend[1]) begin
                grant     = 4'b0010;
                push_code = 2'd1;
            end else if (pend[0]) begin
                grant     = 4'b0001;
                push_code = 2'd0;
            end
        end
    end

    assign push = |grant;

    // A new event on a flag being moved this cycle re-arms it (not a drop);
    // on a flag that stays pending it is lost and counted.
    always_comb begin
        accept    = rise & {NCH{Enable}};
        drop      = accept & pend & ~grant;
        pend_next = (pend & ~grant) | accept;
        n_drop    = '0;
        for (int i = 0; i < NCH; i++) begin
            n_drop = n_drop + 3'(drop[i]);
        end
        drop_sum  = (DROP_W+1)'(drop_cnt) + (DROP_W+1)'(n_drop);
    end

    always_ff @(posedge CLK or negedge n_reset) begin
        if (!n_reset) begin
            pend     <= '0;
            drop_cnt <= '0;
        end else begin
            pend <= pend_next;
            if (drop_sum > (DROP_W+1)'(255)) begin
                drop_cnt <= 8'd255;
            end else begin
                drop_cnt <= drop_sum[DROP_W-1:0];
            end
        end
    end

    // Event FIFO with naturally wrapping pointers.
    always_ff @(posedge CLK or negedge n_reset) begin
        if (!n_reset) begin
            mem        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_code;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    assign coin_valid = (fifo_level != '0);
    assign head       = mem[rd_ptr];

    // Head decode, forced to zero when the queue is empty.
    always_comb begin
        coin_value = '0;
        coin_code  = '0;
        if (coin_valid) begin
            case (head)
                2'd3: begin coin_value = 7'd100; coin_code = 4'b1000; end
                2'd2: begin coin_value = 7'd50;  coin_code = 4'b0100; end
                2'd1: begin coin_value = 7'd10;  coin_code = 4'b0010; end
                default: begin coin_value = 7'd5; coin_code = 4'b0001; end
            endcase
        end
    end

    assign OneDollar_d  = db_lvl[3];
    assign FiftyCents_d = db_lvl[2];
    assign TenCents_d   = db_lvl[1];
    assign FiveCents_d  = db_lvl[0];

endmodule
